rca_op_driver: RTL and testbench



---
 rtl/rca_drv_pkg.sv | 23 ++
 rtl/rca_golden.sv | 15 +
 rtl/rca_op_driver.sv | 150 +++++++++++++++
 tb/tb_rca_op_driver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rca_drv_pkg.sv
// Shared types, default parameters and the reference-sum helper for the
// ripple-carry-adder operand driver and its golden model.
package rca_drv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } drv_state_e;

  localparam int DEF_N      = 4;
  localparam int DEF_SETTLE = 2;
  localparam int DEF_CNT_W  = 16;
  localparam int MAX_W      = 32;

  // Callers zero-extend operands to MAX_W and cast the result back to N+1 bits.
  function automatic logic [MAX_W:0] exp_sum(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input logic             ci);
    return {1'b0, a} + {1'b0, b} + {{MAX_W{1'b0}}, ci};
  endfunction

endpackage

// File: rtl/rca_golden.sv
// Combinational reference adder: exp_o = A + B + Ci, N+1 bits wide.
module rca_golden
  import rca_drv_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         ci_i,
  output logic [N:0]   exp_o
);

  assign exp_o = (N+1)'(exp_sum(MAX_W'(a_i), MAX_W'(b_i), ci_i));

endmodule

// File: rtl/rca_op_driver.sv
// Initiator side of the ripple-carry-adder interface: accepts operand triples,
// drives the adder, samples S/Co after SETTLE cycles and returns the result.
// Optional golden check (out_err, err_cnt) is built when RCA_DRV_CHECK_EN is defined.
module rca_op_driver
  import rca_drv_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_ci,
  output logic [N-1:0]     drv_a,
  output logic [N-1:0]     drv_b,
  output logic             drv_ci,
  input  logic [N-1:0]     mon_s,
  input  logic             mon_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_s,
  output logic             out_co,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int CW = $clog2(SETTLE + 1);

  drv_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    drv_a_q;
  logic [N-1:0]    drv_b_q;
  logic            drv_ci_q;
  logic            out_valid_q;
  logic [N-1:0]    out_s_q;
  logic            out_co_q;

  assign in_ready  = (state_q == IDLE);
  assign drv_a     = drv_a_q;
  assign drv_b     = drv_b_q;
  assign drv_ci    = drv_ci_q;
  assign out_valid = out_valid_q;
  assign out_s     = out_s_q;
  assign out_co    = out_co_q;

  // Transaction FSM; drv_* only move on an accept so the adder never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      drv_a_q     <= {N{1'b0}};
      drv_b_q     <= {N{1'b0}};
      drv_ci_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= {N{1'b0}};
      out_co_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            drv_a_q  <= in_a;
            drv_b_q  <= in_b;
            drv_ci_q <= in_ci;
            cnt_q    <= CW'(SETTLE);
            state_q  <= WAIT;
          end else begin
            state_q  <= IDLE;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            out_s_q     <= mon_s;
            out_co_q    <= mon_co;
            out_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            state_q     <= WAIT;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            state_q     <= RESP;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          cnt_q       <= {CW{1'b0}};
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef RCA_DRV_CHECK_EN
  logic [N:0]       exp_s;
  logic             mismatch_s;
  logic             wait_exit_s;
  logic             out_err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;

  rca_golden #(.N(N)) u_golden (
    .a_i  (drv_a_q),
    .b_i  (drv_b_q),
    .ci_i (drv_ci_q),
    .exp_o(exp_s)
  );

  assign mismatch_s  = ({mon_co, mon_s} != exp_s);
  assign wait_exit_s = (state_q == WAIT) && (cnt_q == CW'(1));
  assign out_err     = out_err_q;
  assign err_cnt     = err_cnt_q;

  // Saturating next value of the mismatch counter.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (wait_exit_s && mismatch_s && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error flag and counter update only at the sampling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_err_q <= 1'b0;
      err_cnt_q <= {CNT_W{1'b0}};
    end else if (wait_exit_s) begin
      out_err_q <= mismatch_s;
      err_cnt_q <= err_cnt_d;
    end else begin
      out_err_q <= out_err_q;
      err_cnt_q <= err_cnt_q;
    end
  end
`else
  assign out_err = 1'b0;
  assign err_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rca_op_driver.sv
// Directed self-checking bench for rca_op_driver (N=4, SETTLE=2) with a
// second CNT_W=2 instance sharing all inputs to observe counter saturation.
module tb_rca_op_driver;

`ifdef RCA_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [3:0]  in_a, in_b;
  logic        in_ci;
  logic [3:0]  drv_a, drv_b, drv_a2, drv_b2;
  logic        drv_ci, drv_ci2;
  logic [3:0]  mon_s;
  logic        mon_co;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [3:0]  out_s, out_s2;
  logic        out_co, out_co2;
  logic        out_err, out_err2;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt2;

  logic        fault_en;
  logic [3:0]  fault_s;
  logic [4:0]  sum_s;
  int          n_pass  = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  rca_op_driver #(.N(4), .SETTLE(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
    .drv_a(drv_a), .drv_b(drv_b), .drv_ci(drv_ci),
    .mon_s(mon_s), .mon_co(mon_co),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_co(out_co), .out_err(out_err), .err_cnt(err_cnt)
  );

  rca_op_driver #(.N(4), .SETTLE(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
    .drv_a(drv_a2), .drv_b(drv_b2), .drv_ci(drv_ci2),
    .mon_s(mon_s), .mon_co(mon_co),
    .out_valid(out_valid2), .out_ready(out_ready),
    .out_s(out_s2), .out_co(out_co2), .out_err(out_err2), .err_cnt(err_cnt2)
  );

  // Behavioural adder behind the driver, with an injectable sum fault.
  always_comb begin
    sum_s  = {1'b0, drv_a} + {1'b0, drv_b} + {4'b0000, drv_ci};
    mon_co = sum_s[4];
    mon_s  = fault_en ? fault_s : sum_s[3:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic ci,
                        input logic [3:0] es, input logic eco, input logic eerr,
                        input int ecnt, input int ecnt2);
    chk("acc_rdy", in_ready, 1);
    in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("wait_rdy", in_ready, 0);
    chk("drv_a", drv_a, a);
    chk("drv_b", drv_b, b);
    chk("drv_ci", drv_ci, ci);
    chk("early_vld1", out_valid, 0);
    tick();
    chk("early_vld2", out_valid, 0);
    tick();
    chk("out_vld", out_valid, 1);
    chk("out_s", out_s, es);
    chk("out_co", out_co, eco);
    chk("out_err", out_err, CHK ? eerr : 1'b0);
    chk("err_cnt", err_cnt, CHK ? ecnt : 0);
    chk("err_cnt2", err_cnt2, CHK ? ecnt2 : 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ret_vld", out_valid, 0);
    chk("ret_rdy", in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0; in_ci = 1'b0;
    out_ready = 1'b0; fault_en = 1'b0; fault_s = 4'd0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_drv_a", drv_a, 0);
    chk("rst_drv_b", drv_b, 0);
    chk("rst_drv_ci", drv_ci, 0);
    chk("rst_out_s", out_s, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_cnt", err_cnt, 0);

    run_op(4'd3,  4'd5,  1'b0, 4'd8,  1'b0, 1'b0, 0, 0);
    run_op(4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0, 0, 0);
    run_op(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, 0, 0);

    fault_en = 1'b1; fault_s = 4'd7;
    run_op(4'd2, 4'd2, 1'b1, 4'd7, 1'b0, 1'b1, 1, 1);
    fault_en = 1'b0;
    run_op(4'd1, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0, 1, 1);

    // Backpressure: result held, new offers ignored while in RESP.
    in_a = 4'd6; in_b = 4'd7; in_ci = 1'b1; in_valid = 1'b1;
    tick();
    in_a = 4'd9; in_b = 4'd9; in_ci = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", out_valid, 1);
      chk("bp_s", out_s, 14);
      chk("bp_co", out_co, 0);
      chk("bp_rdy", in_ready, 0);
      chk("bp_drv_a", drv_a, 6);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_rel_vld", out_valid, 0);
    chk("bp_rel_rdy", in_ready, 1);
    chk("bp_rel_drv_a", drv_a, 6);

    // Reset mid-WAIT with a new triple already offered.
    in_a = 4'd4; in_b = 4'd4; in_ci = 1'b0; in_valid = 1'b1;
    tick();
    in_a = 4'd5; in_b = 4'd6; in_ci = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ra_rdy", in_ready, 1);
    chk("ra_drv_a", drv_a, 0);
    chk("ra_drv_b", drv_b, 0);
    chk("ra_vld", out_valid, 0);
    chk("ra_err_cnt", err_cnt, 0);
    tick();
    in_valid = 1'b0;
    chk("ra_acc_drv_a", drv_a, 5);
    chk("ra_acc_vld", out_valid, 0);
    tick();
    chk("ra_vld1", out_valid, 0);
    tick();
    chk("ra_vld2", out_valid, 1);
    chk("ra_out_s", out_s, 12);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ra_done_rdy", in_ready, 1);

    // Saturation of the 2-bit counter on consecutive mismatches.
    fault_en = 1'b1; fault_s = 4'd0;
    for (int k = 0; k < 5; k++) begin
      run_op(4'd1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b1, k + 1, (k < 2) ? k + 1 : 3);
    end
    fault_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
